// File: rtl/apb_master_bridge_if.sv
// Bundle of the fabric-side request/response handshake and the APB3 bus.
// The master modport is the bridge's view; the slave modport is the opposite side.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready request in, SETUP/ACCESS out,
// one-cycle response strobe back, with a PREADY watchdog against stuck slaves.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);
    localparam int              CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   LAST_WAIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TO_EN     = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         wait_cnt_r;
    logic                  req_ready_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_err_r;
    logic                  rsp_timeout_r;

    // Transfer sequencer; every bus-facing output is a register of this FSM.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r       <= IDLE;
            wait_cnt_r    <= {CW{1'b0}};
            req_ready_r   <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            pwdata_r      <= {DATA_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // req_ready is 0 on the first cycle out of reset, so gate acceptance on it.
                    if (req_ready_r && bus.req_valid) begin
                        pwrite_r    <= bus.req_write;
                        paddr_r     <= bus.req_addr;
                        pwdata_r    <= bus.req_wdata;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        req_ready_r <= 1'b0;
                        wait_cnt_r  <= {CW{1'b0}};
                        state_r     <= SETUP;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= (pwrite_r || bus.PSLVERR) ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
                        rsp_err_r     <= bus.PSLVERR;
                        rsp_timeout_r <= 1'b0;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        req_ready_r   <= 1'b1;
                        state_r       <= IDLE;
                    end else if (TO_EN && (wait_cnt_r == LAST_WAIT)) begin
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        req_ready_r   <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    req_ready_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.PSEL        = psel_r;
    assign bus.PENABLE     = penable_r;
    assign bus.PWRITE      = pwrite_r;
    assign bus.PADDR       = paddr_r;
    assign bus.PWDATA      = pwdata_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: cycle checks in the stimulus thread,
// response payloads checked against a scoreboard queue on the falling edge.
module tb_apb_master_bridge;
    logic PCLK;
    logic PRESET;

    apb_master_bridge_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (!PRESET && bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", bus.rsp_err, e.err);
                chk("rsp_timeout", bus.rsp_timeout, e.to);
            end
        end
    end

    task automatic do_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                           input int waits, input logic [31:0] rd, input logic serr);
        exp_t e;
        chk("idle_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.PRDATA    = rd;
        bus.PSLVERR   = serr;
        bus.PREADY    = 1'b0;
        if (waits >= 16) begin
            e.rdata = 32'h0; e.err = 1'b1; e.to = 1'b1;
        end else begin
            e.rdata = (w || serr) ? 32'h0 : rd; e.err = serr; e.to = 1'b0;
        end
        sb.push_back(e);
        step();
        bus.req_valid = 1'b0;
        chk("setup_psel", bus.PSEL, 1'b1);
        chk("setup_penable", bus.PENABLE, 1'b0);
        chk("setup_ready", bus.req_ready, 1'b0);
        chk("setup_paddr", bus.PADDR, a);
        chk("setup_pwrite", bus.PWRITE, w);
        chk("setup_pwdata", bus.PWDATA, d);
        step();
        for (int k = 0; k < 16; k++) begin
            chk("acc_psel", bus.PSEL, 1'b1);
            chk("acc_penable", bus.PENABLE, 1'b1);
            chk("acc_paddr", bus.PADDR, a);
            chk("acc_pwrite", bus.PWRITE, w);
            chk("acc_pwdata", bus.PWDATA, d);
            chk("acc_no_rsp", bus.rsp_valid, 1'b0);
            bus.PREADY = (k == waits);
            step();
            if (k == waits) break;
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        chk("done_rsp_valid", bus.rsp_valid, 1'b1);
        chk("done_psel", bus.PSEL, 1'b0);
        chk("done_penable", bus.PENABLE, 1'b0);
        chk("done_ready", bus.req_ready, 1'b1);
    endtask

    initial begin
        logic        bw [3];
        logic [2:0]  ba [3];
        logic [31:0] bd [3];
        exp_t        e;

        PRESET        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 3'd0;
        bus.req_wdata = 32'h0;
        bus.PRDATA    = 32'h0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        step();
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_psel", bus.PSEL, 1'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_paddr", bus.PADDR, 3'd0);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        PRESET = 1'b0;
        step();
        chk("rel_ready", bus.req_ready, 1'b1);

        do_xfer(1'b0, 3'd2, 32'h1111_2222, 0,   32'hCAFE_0001, 1'b0);
        do_xfer(1'b1, 3'd0, 32'h0000_1000, 3,   32'hDEAD_BEEF, 1'b0);
        do_xfer(1'b0, 3'd1, 32'h0,         1,   32'h1234_5678, 1'b1);
        do_xfer(1'b0, 3'd3, 32'h0,         100, 32'h7777_7777, 1'b0);
        do_xfer(1'b0, 3'd4, 32'h0,         15,  32'hA5A5_5A5A, 1'b0);

        // Back-to-back: request held high, swapped only after each accept edge.
        bw[0] = 1'b1; ba[0] = 3'd4; bd[0] = 32'h0000_00A1;
        bw[1] = 1'b1; ba[1] = 3'd6; bd[1] = 32'h0000_00B2;
        bw[2] = 1'b0; ba[2] = 3'd7; bd[2] = 32'h0000_00C3;
        bus.PREADY  = 1'b1;
        bus.PRDATA  = 32'h0BAD_F00D;
        bus.PSLVERR = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.req_valid = 1'b1;
            bus.req_write = bw[j];
            bus.req_addr  = ba[j];
            bus.req_wdata = bd[j];
            e.rdata = bw[j] ? 32'h0 : 32'h0BAD_F00D; e.err = 1'b0; e.to = 1'b0;
            sb.push_back(e);
            step();
            chk("b2b_setup_psel", bus.PSEL, 1'b1);
            chk("b2b_setup_penable", bus.PENABLE, 1'b0);
            chk("b2b_paddr", bus.PADDR, ba[j]);
            chk("b2b_pwdata", bus.PWDATA, bd[j]);
            step();
            chk("b2b_acc_penable", bus.PENABLE, 1'b1);
            chk("b2b_acc_paddr", bus.PADDR, ba[j]);
            step();
            chk("b2b_rsp_valid", bus.rsp_valid, 1'b1);
            chk("b2b_ready", bus.req_ready, 1'b1);
        end
        bus.req_valid = 1'b0;
        bus.PREADY    = 1'b0;
        step();
        chk("b2b_idle_psel", bus.PSEL, 1'b0);

        // Reset during an ACCESS wait state: no response may appear.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 3'd5;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("mid_penable", bus.PENABLE, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("mid_rst_psel", bus.PSEL, 1'b0);
        chk("mid_rst_penable", bus.PENABLE, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 1'b0);
        chk("mid_rst_rsp", bus.rsp_valid, 1'b0);
        step();
        step();
        PRESET = 1'b0;
        chk("mid_rel_ready0", bus.req_ready, 1'b0);
        step();
        chk("mid_rel_no_rsp", bus.rsp_valid, 1'b0);
        do_xfer(1'b0, 3'd5, 32'h0, 0, 32'h5555_AAAA, 1'b0);

        step();
        step();
        chk("sb_empty", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
